// File: rtl/br_pred_ctrl.sv
// Branch predictor update controller.
// After reset or a table clear, it sweeps the branch table and invalidates every entry.
// It queues resolved branch updates and writes them into the table while predicting.
// It also issues a registered fetch redirect whenever a branch was mispredicted.
module br_pred_ctrl #(
   parameter int IDX_W      = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_br_update_en,
   input  logic                i_br_update_valid,
   input  logic                i_br_update_taken,
   input  logic                i_br_update_already_prd,
   input  logic [31:0]         i_br_update_pc,
   input  logic [31:0]         i_br_update_target,
   input  logic [31:0]         i_br_update_prd_target,
   input  logic                i_tbl_clear,
   input  logic                i_tbl_wr_ready,
   output logic                o_tbl_wr_en,
   output logic [IDX_W-1:0]    o_tbl_wr_idx,
   output logic [29-IDX_W:0]   o_tbl_wr_tag,
   output logic [31:0]         o_tbl_wr_target,
   output logic                o_tbl_wr_taken,
   output logic                o_tbl_wr_valid,
   output logic                o_redirect_en,
   output logic [31:0]         o_redirect_pc,
   output logic                o_pred_enable,
   output logic [7:0]          o_drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   typedef enum logic {INIT, RUN} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     init_idx_q, init_idx_d;

   // Update queue: word-aligned PC (bits 31:2), actual target, actual outcome.
   logic [29:0]          fifo_pc  [FIFO_DEPTH];
   logic [31:0]          fifo_tgt [FIFO_DEPTH];
   logic                 fifo_tkn [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [PTR_W:0]       count;
   logic [7:0]           drop_cnt;

   logic                 fifo_full, fifo_empty, fifo_flush;
   logic                 qual, enq, deq, drop, mispred;
   logic [31:0]          redir_pc_p0;
   logic                 redir_vld_p1;
   logic [31:0]          redir_pc_p1;
   logic [29:0]          head_pc;

   assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign head_pc    = fifo_pc[rd_ptr];

   // A clear drops the queued updates while predicting, and an update that arrives in the same cycle is not queued.
   assign qual       = i_br_update_en & i_br_update_valid;
   assign fifo_flush = (state_q == RUN) & i_tbl_clear;
   assign deq        = (state_q == RUN) & ~fifo_empty & ~i_tbl_clear & i_tbl_wr_ready;
   assign enq        = qual & ~i_tbl_clear & (~fifo_full | deq);
   assign drop       = qual & ~i_tbl_clear & fifo_full & ~deq;

   // Wrong direction, or taken with a wrong predicted target.
   assign mispred     = qual & ((i_br_update_taken != i_br_update_already_prd) |
                                (i_br_update_taken & i_br_update_already_prd &
                                 (i_br_update_target != i_br_update_prd_target)));
   assign redir_pc_p0 = i_br_update_taken ? i_br_update_target : (i_br_update_pc + 32'd4);

   // Next state and next init index: the sweep advances only when a write is accepted.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      unique case (state_q)
         INIT: begin
            if (i_tbl_clear) begin
               init_idx_d = '0;
            end else if (i_tbl_wr_ready) begin
               if (init_idx_q == LAST_IDX) begin
                  state_d    = RUN;
                  init_idx_d = '0;
               end else begin
                  init_idx_d = init_idx_q + IDX_W'(1);
               end
            end
         end
         RUN: begin
            if (i_tbl_clear) begin
               state_d    = INIT;
               init_idx_d = '0;
            end
         end
         default: begin
            state_d    = INIT;
            init_idx_d = '0;
         end
      endcase
   end

   // Table write request: the invalidate sweep in INIT, the queue head in RUN.
   always_comb begin
      o_tbl_wr_en     = 1'b0;
      o_tbl_wr_idx    = '0;
      o_tbl_wr_tag    = '0;
      o_tbl_wr_target = '0;
      o_tbl_wr_taken  = 1'b0;
      o_tbl_wr_valid  = 1'b0;
      if (state_q == INIT) begin
         o_tbl_wr_en  = 1'b1;
         o_tbl_wr_idx = init_idx_q;
      end else if (!fifo_empty && !i_tbl_clear) begin
         o_tbl_wr_en     = 1'b1;
         o_tbl_wr_idx    = head_pc[IDX_W-1:0];
         o_tbl_wr_tag    = head_pc[29:IDX_W];
         o_tbl_wr_target = fifo_tgt[rd_ptr];
         o_tbl_wr_taken  = fifo_tkn[rd_ptr];
         o_tbl_wr_valid  = 1'b1;
      end
   end

   // Control state: FSM, sweep index, queue pointers and the saturating drop counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= INIT;
         init_idx_q <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         drop_cnt   <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         if (fifo_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({enq, deq})
               2'b10:   count <= count + (PTR_W+1)'(1);
               2'b01:   count <= count - (PTR_W+1)'(1);
               default: count <= count;
            endcase
         end
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Queue storage is data only and is not reset. The pointers and the count decide which entries are live.
   always_ff @(posedge i_clk) begin
      if (enq) begin
         fifo_pc[wr_ptr]  <= i_br_update_pc[31:2];
         fifo_tgt[wr_ptr] <= i_br_update_target;
         fifo_tkn[wr_ptr] <= i_br_update_taken;
      end
   end

   // Stage p0 -> p1: redirect strobe and its PC, which holds its last value between redirects.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         redir_vld_p1 <= 1'b0;
         redir_pc_p1  <= '0;
      end else begin
         redir_vld_p1 <= mispred;
         if (mispred) redir_pc_p1 <= redir_pc_p0;
      end
   end

   assign o_redirect_en = redir_vld_p1;
   assign o_redirect_pc = redir_pc_p1;
   assign o_pred_enable = (state_q == RUN);
   assign o_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed testbench for br_pred_ctrl.
// Inputs change 1 ns after the falling edge and outputs are sampled 1 ns later.
module tb_br_pred_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        br_en, br_valid, br_taken, br_already;
   logic [31:0] br_pc, br_target, br_prd_target;
   logic        tbl_clear, tbl_ready;
   logic        wr_en;
   logic [5:0]  wr_idx;
   logic [23:0] wr_tag;
   logic [31:0] wr_target;
   logic        wr_taken, wr_valid;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        pred_enable;
   logic [7:0]  drop_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   br_pred_ctrl #(.IDX_W(6), .FIFO_DEPTH(4)) dut (
      .i_clk                   (clk),
      .i_rst                   (rst),
      .i_br_update_en          (br_en),
      .i_br_update_valid       (br_valid),
      .i_br_update_taken       (br_taken),
      .i_br_update_already_prd (br_already),
      .i_br_update_pc          (br_pc),
      .i_br_update_target      (br_target),
      .i_br_update_prd_target  (br_prd_target),
      .i_tbl_clear             (tbl_clear),
      .i_tbl_wr_ready          (tbl_ready),
      .o_tbl_wr_en             (wr_en),
      .o_tbl_wr_idx            (wr_idx),
      .o_tbl_wr_tag            (wr_tag),
      .o_tbl_wr_target         (wr_target),
      .o_tbl_wr_taken          (wr_taken),
      .o_tbl_wr_valid          (wr_valid),
      .o_redirect_en           (redirect_en),
      .o_redirect_pc           (redirect_pc),
      .o_pred_enable           (pred_enable),
      .o_drop_cnt              (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tkn, input logic ap, input logic [31:0] ptgt);
      br_en = 1'b1; br_valid = 1'b1; br_pc = pc; br_target = tgt;
      br_taken = tkn; br_already = ap; br_prd_target = ptgt;
   endtask

   task automatic idle();
      br_en = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_already = 1'b0;
      br_pc = '0; br_target = '0; br_prd_target = '0;
   endtask

   task automatic test_reset();
      logic [42:0] act, exp;
      rst = 1'b0; tbl_ready = 1'b1; tbl_clear = 1'b0; idle();
      repeat (3) next_cycle();
      #1;
      act = {pred_enable, redirect_en, redirect_pc, wr_en, wr_valid, drop_cnt[0]};
      exp = {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (act !== exp || drop_cnt !== 8'd0 || wr_idx !== 6'd0)
         $display("FAIL reset_state: got %h idx %0d drop %0d, expected %h idx 0 drop 0", act, wr_idx, drop_cnt, exp);
      else pass_cnt++;
   endtask

   task automatic test_init_sweep();
      logic [9:0] act, exp;
      next_cycle();
      rst = 1'b1; tbl_ready = 1'b0;
      next_cycle();
      total_cnt++;
      if (wr_en !== 1'b1 || wr_idx !== 6'd0)
         $display("FAIL init_stall: got en %b idx %0d, expected en 1 idx 0", wr_en, wr_idx);
      else pass_cnt++;
      tbl_ready = 1'b1;
      #1;
      for (int k = 0; k < 64; k++) begin
         act = {wr_en, wr_idx, wr_valid, wr_taken, pred_enable};
         exp = {1'b1, 6'(k), 1'b0, 1'b0, 1'b0};
         total_cnt++;
         if (act !== exp || wr_tag !== 24'h0 || wr_target !== 32'h0)
            $display("FAIL init_write_%0d: got %h, expected %h", k, act, exp);
         else pass_cnt++;
         next_cycle();
      end
      total_cnt++;
      if (pred_enable !== 1'b1 || wr_en !== 1'b0)
         $display("FAIL init_done: got pred %b en %b, expected pred 1 en 0", pred_enable, wr_en);
      else pass_cnt++;
   endtask

   task automatic test_mispredict_taken();
      logic [64:0] act, exp;
      present(32'h0000_0104, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
      next_cycle();
      idle(); #1;
      total_cnt++;
      if (redirect_en !== 1'b1 || redirect_pc !== 32'h200)
         $display("FAIL mispred_redirect: got en %b pc %h, expected en 1 pc 00000200", redirect_en, redirect_pc);
      else pass_cnt++;
      act = {wr_en, wr_idx, wr_tag, wr_target, wr_taken, wr_valid};
      exp = {1'b1, 6'h01, 24'h000001, 32'h200, 1'b1, 1'b1};
      total_cnt++;
      if (act !== exp) $display("FAIL mispred_write: got %h, expected %h", act, exp);
      else pass_cnt++;
      next_cycle();
      total_cnt++;
      if (redirect_en !== 1'b0 || redirect_pc !== 32'h200 || wr_en !== 1'b0)
         $display("FAIL mispred_pulse_end: got en %b pc %h wr %b, expected en 0 pc 00000200 wr 0", redirect_en, redirect_pc, wr_en);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [64:0] act, exp;
      present(32'hFFFF_FFFC, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_1234);
      next_cycle();
      idle(); #1;
      total_cnt++;
      if (redirect_en !== 1'b1 || redirect_pc !== 32'h0)
         $display("FAIL wrap_redirect: got en %b pc %h, expected en 1 pc 00000000", redirect_en, redirect_pc);
      else pass_cnt++;
      act = {wr_en, wr_idx, wr_tag, wr_target, wr_taken, wr_valid};
      exp = {1'b1, 6'h3F, 24'hFFFFFF, 32'h1234, 1'b0, 1'b1};
      total_cnt++;
      if (act !== exp) $display("FAIL wrap_write: got %h, expected %h", act, exp);
      else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_prediction_cases();
      // columns: en valid taken already target prd_target, expected redirect, expected write
      logic [5:0]  ctl  [5];
      logic [31:0] tgt  [5];
      logic [31:0] ptgt [5];
      logic [31:0] exp_rpc;
      ctl[0] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; tgt[0] = 32'h300; ptgt[0] = 32'h300;
      ctl[1] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}; tgt[1] = 32'h300; ptgt[1] = 32'h304;
      ctl[2] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; tgt[2] = 32'h700; ptgt[2] = 32'h0;
      ctl[3] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; tgt[3] = 32'h800; ptgt[3] = 32'h0;
      ctl[4] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; tgt[4] = 32'h900; ptgt[4] = 32'h0;
      exp_rpc = 32'h0;
      for (int i = 0; i < 5; i++) begin
         br_en = ctl[i][5]; br_valid = ctl[i][4]; br_taken = ctl[i][3]; br_already = ctl[i][2];
         br_pc = 32'h500 + 32'(i * 4); br_target = tgt[i]; br_prd_target = ptgt[i];
         if (ctl[i][1]) exp_rpc = tgt[i];
         next_cycle();
         idle(); #1;
         total_cnt++;
         if ({redirect_en, wr_en} !== ctl[i][1:0] || redirect_pc !== exp_rpc)
            $display("FAIL pred_case_%0d: got redirect %b write %b pc %h, expected redirect %b write %b pc %h",
                     i, redirect_en, wr_en, redirect_pc, ctl[i][1], ctl[i][0], exp_rpc);
         else pass_cnt++;
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      present(32'h0000_1000, 32'h0000_9000, 1'b0, 1'b1, 32'h0000_9000);
      next_cycle();
      present(32'h0000_2000, 32'h0000_3000, 1'b1, 1'b0, 32'h0);
      #1;
      total_cnt++;
      if (redirect_en !== 1'b1 || redirect_pc !== 32'h1004)
         $display("FAIL b2b_first: got en %b pc %h, expected en 1 pc 00001004", redirect_en, redirect_pc);
      else pass_cnt++;
      next_cycle();
      idle(); #1;
      total_cnt++;
      if (redirect_en !== 1'b1 || redirect_pc !== 32'h3000)
         $display("FAIL b2b_second: got en %b pc %h, expected en 1 pc 00003000", redirect_en, redirect_pc);
      else pass_cnt++;
      next_cycle();
      total_cnt++;
      if (redirect_en !== 1'b0 || redirect_pc !== 32'h3000 || wr_en !== 1'b0)
         $display("FAIL b2b_end: got en %b pc %h wr %b, expected en 0 pc 00003000 wr 0", redirect_en, redirect_pc, wr_en);
      else pass_cnt++;
   endtask

   task automatic test_fifo_full();
      logic [62:0] act, exp;
      tbl_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         present(32'h1000_0000 + 32'((i + 1) * 16), 32'h5000 + 32'(i), 1'b1, 1'b1, 32'h5000 + 32'(i));
         #1;
         act = {wr_en, wr_idx, wr_tag, wr_target};
         exp = (i == 0) ? 63'h0 : {1'b1, 6'd4, 24'h100000, 32'h5000};
         total_cnt++;
         if (act !== exp) $display("FAIL stall_hold_%0d: got %h, expected %h", i, act, exp);
         else pass_cnt++;
         next_cycle();
      end
      idle(); #1;
      total_cnt++;
      if (drop_cnt !== 8'd2 || wr_idx !== 6'd4 || wr_target !== 32'h5000)
         $display("FAIL full_drop: got drop %0d idx %0d tgt %h, expected drop 2 idx 4 tgt 00005000", drop_cnt, wr_idx, wr_target);
      else pass_cnt++;
      tbl_ready = 1'b1; #1;
      for (int j = 0; j < 4; j++) begin
         total_cnt++;
         if (wr_en !== 1'b1 || wr_idx !== 6'(4 * (j + 1)) || wr_target !== 32'h5000 + 32'(j))
            $display("FAIL drain_%0d: got en %b idx %0d tgt %h, expected en 1 idx %0d tgt %h",
                     j, wr_en, wr_idx, wr_target, 4 * (j + 1), 32'h5000 + 32'(j));
         else pass_cnt++;
         next_cycle();
      end
      total_cnt++;
      if (wr_en !== 1'b0) $display("FAIL drain_empty: got en %b, expected 0", wr_en);
      else pass_cnt++;
   endtask

   task automatic test_drop_saturate();
      tbl_ready = 1'b0;
      for (int n = 1; n <= 259; n++) begin
         present(32'h0000_4000, 32'h0000_6000, 1'b1, 1'b1, 32'h0000_6000);
         next_cycle();
         if (n == 256) begin
            total_cnt++;
            if (drop_cnt !== 8'd254) $display("FAIL drop_254: got %0d, expected 254", drop_cnt);
            else pass_cnt++;
         end
         if (n == 257 || n == 259) begin
            total_cnt++;
            if (drop_cnt !== 8'd255) $display("FAIL drop_sat_%0d: got %0d, expected 255", n, drop_cnt);
            else pass_cnt++;
         end
      end
      idle();
      tbl_ready = 1'b1;
      repeat (4) next_cycle();
      total_cnt++;
      if (wr_en !== 1'b0) $display("FAIL sat_drain: got en %b, expected 0", wr_en);
      else pass_cnt++;
   endtask

   task automatic test_clear();
      logic [8:0] act, exp;
      tbl_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         present(32'h2000_0040 + 32'(i * 4), 32'h7000, 1'b0, 1'b0, 32'h0);
         next_cycle();
      end
      idle();
      tbl_clear = 1'b1; #1;
      total_cnt++;
      if (wr_en !== 1'b0 || pred_enable !== 1'b1)
         $display("FAIL clear_suppress: got en %b pred %b, expected en 0 pred 1", wr_en, pred_enable);
      else pass_cnt++;
      next_cycle();
      tbl_clear = 1'b0; tbl_ready = 1'b1; #1;
      for (int k = 0; k < 5; k++) begin
         total_cnt++;
         if (wr_en !== 1'b1 || wr_idx !== 6'(k) || pred_enable !== 1'b0)
            $display("FAIL clear_sweep_%0d: got en %b idx %0d pred %b, expected en 1 idx %0d pred 0", k, wr_en, wr_idx, pred_enable, k);
         else pass_cnt++;
         next_cycle();
      end
      tbl_clear = 1'b1; #1;
      next_cycle();
      tbl_clear = 1'b0; #1;
      for (int k = 0; k < 64; k++) begin
         act = {wr_en, wr_idx, wr_valid, pred_enable};
         exp = {1'b1, 6'(k), 1'b0, 1'b0};
         total_cnt++;
         if (act !== exp) $display("FAIL resweep_%0d: got %h, expected %h", k, act, exp);
         else pass_cnt++;
         next_cycle();
      end
      total_cnt++;
      if (pred_enable !== 1'b1 || wr_en !== 1'b0)
         $display("FAIL clear_done: got pred %b en %b, expected pred 1 en 0", pred_enable, wr_en);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_init();
      logic [42:0] act, exp;
      tbl_clear = 1'b1; #1;
      next_cycle();
      tbl_clear = 1'b0; tbl_ready = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         if (k == 10) present(32'h0000_0040, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
         else idle();
         #1;
         if (k == 11) begin
            total_cnt++;
            if (redirect_en !== 1'b1 || redirect_pc !== 32'h80)
               $display("FAIL init_redirect: got en %b pc %h, expected en 1 pc 00000080", redirect_en, redirect_pc);
            else pass_cnt++;
         end
         if (k == 30) begin
            total_cnt++;
            if (wr_idx !== 6'd30) $display("FAIL pre_reset_idx: got %0d, expected 30", wr_idx);
            else pass_cnt++;
         end
         if (k < 30) next_cycle();
      end
      rst = 1'b0;
      next_cycle();
      act = {pred_enable, redirect_en, redirect_pc, wr_en, wr_valid, wr_idx == 6'd0};
      exp = {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
      total_cnt++;
      if (act !== exp || drop_cnt !== 8'd0)
         $display("FAIL mid_reset: got %h drop %0d, expected %h drop 0", act, drop_cnt, exp);
      else pass_cnt++;
      rst = 1'b1; #1;
      for (int k = 0; k < 64; k++) begin
         total_cnt++;
         if (wr_en !== 1'b1 || wr_idx !== 6'(k) || wr_valid !== 1'b0 || pred_enable !== 1'b0)
            $display("FAIL post_reset_sweep_%0d: got en %b idx %0d pred %b, expected en 1 idx %0d pred 0", k, wr_en, wr_idx, pred_enable, k);
         else pass_cnt++;
         next_cycle();
      end
      total_cnt++;
      if (pred_enable !== 1'b1 || wr_en !== 1'b0)
         $display("FAIL post_reset_run: got pred %b en %b, expected pred 1 en 0", pred_enable, wr_en);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_mispredict_taken();
      test_wrap();
      test_prediction_cases();
      test_back_to_back();
      test_fifo_full();
      test_drop_saturate();
      test_clear();
      test_reset_mid_init();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
